// File: rtl/csb_pkg.sv
// Shared definitions for the command sequencer: FSM state codes, op_type codes,
// command word layout and the op_type to engine mapping.
package csb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_OP = 3'd3,
    ST_FINISH  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam logic [2:0] OP_CONV_A  = 3'd1;
  localparam logic [2:0] OP_CONV_B  = 3'd2;
  localparam logic [2:0] OP_CONV_C  = 3'd3;
  localparam logic [2:0] OP_MAXPOOL = 3'd4;
  localparam logic [2:0] OP_AVEPOOL = 3'd5;

  localparam int WORD_CTRL  = 0;
  localparam int WORD_CH    = 1;
  localparam int WORD_SIDE  = 2;
  localparam int WORD_WADDR = 3;
  localparam int WORD_DADDR = 4;
  localparam int WORD_RADDR = 5;

  localparam logic [1:0] ENG_CONV    = 2'd0;
  localparam logic [1:0] ENG_MAXPOOL = 2'd1;
  localparam logic [1:0] ENG_AVEPOOL = 2'd2;

  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_CONV_A, OP_CONV_B, OP_CONV_C, OP_MAXPOOL, OP_AVEPOOL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] op_engine(input logic [2:0] op);
    logic [1:0] eng;
    case (op)
      OP_CONV_A, OP_CONV_B, OP_CONV_C: eng = ENG_CONV;
      OP_MAXPOOL:                      eng = ENG_MAXPOOL;
      OP_AVEPOOL:                      eng = ENG_AVEPOOL;
      default:                         eng = ENG_CONV;
    endcase
    return eng;
  endfunction

endpackage

// File: rtl/csb_op_tracker.sv
// Surface/channel progress of the running op. Each engine pulse finishes one surface;
// a full surface sweep finishes PARA output channels, the last sweep may be ragged.
module csb_op_tracker #(
  parameter int CNT_W = 16,
  parameter int PARA  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_pulse,
  input  logic [CNT_W-1:0] i_o_ch,
  input  logic [CNT_W-1:0] i_o_surf,
  output logic             o_op_last
);

  localparam logic [CNT_W:0] C_PARA = (CNT_W+1)'(PARA);

  logic [CNT_W-1:0] r_surf;
  logic [CNT_W-1:0] r_ch;
  logic             w_surf_last;
  logic [CNT_W:0]   w_ch_next;
  logic             w_ch_done;

  assign w_surf_last = (r_surf == (i_o_surf - CNT_W'(1)));
  // one extra bit so ch+PARA cannot wrap before the compare
  assign w_ch_next   = {1'b0, r_ch} + C_PARA;
  assign w_ch_done   = (w_ch_next >= {1'b0, i_o_ch});
  assign o_op_last   = i_pulse && w_surf_last && w_ch_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_surf <= {CNT_W{1'b0}};
      r_ch   <= {CNT_W{1'b0}};
    end else if (i_clr || o_op_last) begin
      r_surf <= {CNT_W{1'b0}};
      r_ch   <= {CNT_W{1'b0}};
    end else if (i_pulse) begin
      if (w_surf_last) begin
        r_surf <= {CNT_W{1'b0}};
        r_ch   <= w_ch_next[CNT_W-1:0];
      end else begin
        r_surf <= r_surf + CNT_W'(1);
        r_ch   <= r_ch;
      end
    end else begin
      r_surf <= r_surf;
      r_ch   <= r_ch;
    end
  end

endmodule

// File: rtl/csb_seq.sv
// Command sequencer: collects multi-word layer commands from an FWFT FIFO, dispatches
// each to one engine, tracks its progress and raises a sticky irq after the program.
module csb_seq #(
  parameter int CMD_W     = 32,
  parameter int CMD_WORDS = 6,
  parameter int PARA      = 16,
  parameter int CNT_W     = 16,
  parameter int ADDR_W    = 32,
  parameter int N_ENG     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_en,
  input  logic              abort,
  input  logic              irq_clr,
  input  logic [6:0]        cmd_size,
  input  logic [9:0]        cmd_fifo_wr_count,
  input  logic              cmd_fifo_empty,
  input  logic [CMD_W-1:0]  cmd,
  output logic              cmd_fifo_rd_en,
  output logic              dma_reads_en,
  output logic [N_ENG-1:0]  eng_ready,
  input  logic [N_ENG-1:0]  eng_valid,
  output logic [2:0]        op_type,
  output logic              padding,
  output logic [3:0]        stride,
  output logic [19:0]       op_num,
  output logic [CNT_W-1:0]  i_ch,
  output logic [CNT_W-1:0]  o_ch,
  output logic [7:0]        i_side,
  output logic [7:0]        o_side,
  output logic [CNT_W-1:0]  o_surf,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] result_addr,
  output logic              engine_reset,
  output logic              irq,
  output logic              err,
  output logic [6:0]        cmd_idx
);
  import csb_pkg::*;

  localparam int WIDX_W = $clog2(CMD_WORDS);
  localparam logic [WIDX_W-1:0] C_LAST_WORD = WIDX_W'(CMD_WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WIDX_W-1:0] r_word;
  logic              w_pop;
  logic              w_issue_ok;
  logic              w_prog_last;
  logic              w_pulse;
  logic              w_op_last;
  logic              w_trk_clr;
  logic              w_start;
  logic [1:0]        w_eng;
  logic [12:0]       w_need;

  logic [N_ENG-1:0]  r_eng_ready;
  logic              r_dma;
  logic              r_engine_reset;
  logic              r_irq;
  logic              r_err;
  logic [6:0]        r_cmd_idx;
  logic [2:0]        r_op_type;
  logic              r_padding;
  logic [3:0]        r_stride;
  logic [19:0]       r_op_num;
  logic [CNT_W-1:0]  r_i_ch;
  logic [CNT_W-1:0]  r_o_ch;
  logic [7:0]        r_i_side;
  logic [7:0]        r_o_side;
  logic [CNT_W-1:0]  r_o_surf;
  logic [ADDR_W-1:0] r_weight_addr;
  logic [ADDR_W-1:0] r_data_addr;
  logic [ADDR_W-1:0] r_result_addr;

  assign w_issue_ok  = op_legal(r_op_type) && (r_o_ch != {CNT_W{1'b0}}) &&
                       (r_o_surf != {CNT_W{1'b0}}) && (cmd_size != 7'd0);
  assign w_prog_last = ((r_cmd_idx + 7'd1) == cmd_size);
  assign w_eng       = op_engine(r_op_type);
  assign w_start     = (r_state == ST_IDLE) && op_en && !abort;
  // eng_ready is one-hot on the dispatched engine, so it doubles as the valid mask
  assign w_pulse     = (r_state == ST_WAIT_OP) && !abort && (|(eng_valid & r_eng_ready));
  assign w_trk_clr   = abort || (r_state == ST_ISSUE);
  assign w_need      = 13'(cmd_size) * 13'(CMD_WORDS);

  csb_op_tracker #(
    .CNT_W (CNT_W),
    .PARA  (PARA)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_trk_clr),
    .i_pulse   (w_pulse),
    .i_o_ch    (r_o_ch),
    .i_o_surf  (r_o_surf),
    .o_op_last (w_op_last)
  );

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_next = op_en ? ST_COLLECT : ST_IDLE;
        ST_COLLECT: begin
          w_pop  = !cmd_fifo_empty;
          w_next = (w_pop && (r_word == C_LAST_WORD)) ? ST_ISSUE : ST_COLLECT;
        end
        ST_ISSUE:   w_next = w_issue_ok ? ST_WAIT_OP : ST_ERROR;
        ST_WAIT_OP: begin
          if (w_op_last) begin
            w_next = w_prog_last ? ST_FINISH : ST_COLLECT;
          end else begin
            w_next = ST_WAIT_OP;
          end
        end
        ST_FINISH:  w_next = irq_clr ? ST_IDLE : ST_FINISH;
        ST_ERROR:   w_next = ST_ERROR;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  assign cmd_fifo_rd_en = w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_word         <= {WIDX_W{1'b0}};
      r_eng_ready    <= {N_ENG{1'b0}};
      r_engine_reset <= 1'b1;
    end else begin
      r_state        <= w_next;
      if (w_pop) begin
        r_word <= (r_word == C_LAST_WORD) ? {WIDX_W{1'b0}} : r_word + WIDX_W'(1);
      end else if (r_state != ST_COLLECT) begin
        r_word <= {WIDX_W{1'b0}};
      end else begin
        r_word <= r_word;
      end
      if (w_next != ST_WAIT_OP) begin
        r_eng_ready <= {N_ENG{1'b0}};
      end else if (r_state == ST_ISSUE) begin
        r_eng_ready <= N_ENG'(1'b1) << w_eng;
      end else begin
        r_eng_ready <= r_eng_ready;
      end
      r_engine_reset <= (w_next != ST_WAIT_OP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dma     <= 1'b0;
      r_irq     <= 1'b0;
      r_err     <= 1'b0;
      r_cmd_idx <= 7'd0;
    end else begin
      if (abort) begin
        r_dma <= 1'b0;
      end else if (w_start) begin
        r_dma <= 1'b1;
      end else if ({3'd0, cmd_fifo_wr_count} >= w_need) begin
        r_dma <= 1'b0;
      end else begin
        r_dma <= r_dma;
      end
      // irq follows FINISH by one cycle and stays until cleared
      if (abort) begin
        r_irq <= 1'b0;
      end else if (r_state == ST_FINISH) begin
        r_irq <= !irq_clr;
      end else begin
        r_irq <= r_irq;
      end
      if (w_start) begin
        r_err <= 1'b0;
      end else if ((r_state == ST_ISSUE) && !abort && !w_issue_ok) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
      if (w_start) begin
        r_cmd_idx <= 7'd0;
      end else if (w_op_last) begin
        r_cmd_idx <= r_cmd_idx + 7'd1;
      end else begin
        r_cmd_idx <= r_cmd_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_type     <= 3'd0;
      r_padding     <= 1'b0;
      r_stride      <= 4'd0;
      r_op_num      <= 20'd0;
      r_i_ch        <= {CNT_W{1'b0}};
      r_o_ch        <= {CNT_W{1'b0}};
      r_i_side      <= 8'd0;
      r_o_side      <= 8'd0;
      r_o_surf      <= {CNT_W{1'b0}};
      r_weight_addr <= {ADDR_W{1'b0}};
      r_data_addr   <= {ADDR_W{1'b0}};
      r_result_addr <= {ADDR_W{1'b0}};
    end else if (w_pop) begin
      case (r_word)
        WIDX_W'(WORD_CTRL): begin
          r_op_type <= cmd[2:0];
          r_padding <= cmd[3];
          r_stride  <= cmd[7:4];
          r_op_num  <= cmd[27:8];
        end
        WIDX_W'(WORD_CH): begin
          r_i_ch <= CNT_W'(cmd[15:0]);
          r_o_ch <= CNT_W'(cmd[31:16]);
        end
        WIDX_W'(WORD_SIDE): begin
          r_i_side <= cmd[7:0];
          r_o_side <= cmd[15:8];
          r_o_surf <= CNT_W'(cmd[31:16]);
        end
        WIDX_W'(WORD_WADDR): r_weight_addr <= ADDR_W'(cmd);
        WIDX_W'(WORD_DADDR): r_data_addr   <= ADDR_W'(cmd);
        WIDX_W'(WORD_RADDR): r_result_addr <= ADDR_W'(cmd);
        default: ;
      endcase
    end
  end

  assign dma_reads_en = r_dma;
  assign eng_ready    = r_eng_ready;
  assign engine_reset = r_engine_reset;
  assign irq          = r_irq;
  assign err          = r_err;
  assign cmd_idx      = r_cmd_idx;
  assign op_type      = r_op_type;
  assign padding      = r_padding;
  assign stride       = r_stride;
  assign op_num       = r_op_num;
  assign i_ch         = r_i_ch;
  assign o_ch         = r_o_ch;
  assign i_side       = r_i_side;
  assign o_side       = r_o_side;
  assign o_surf       = r_o_surf;
  assign weight_addr  = r_weight_addr;
  assign data_addr    = r_data_addr;
  assign result_addr  = r_result_addr;

endmodule

// File: tb/tb_csb_seq.sv
// Randomised bench for csb_seq: a FIFO model feeds command words, an engine model
// answers eng_ready with pulses, expectations come from ceil-based op lengths.
module tb_csb_seq;

  typedef struct {
    logic [2:0]  op;
    logic        pad;
    logic [3:0]  stride;
    logic [19:0] num;
    logic [15:0] ich;
    logic [15:0] och;
    logic [7:0]  iside;
    logic [7:0]  oside;
    logic [15:0] osurf;
    logic [31:0] wa;
    logic [31:0] da;
    logic [31:0] ra;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n, op_en, abort, irq_clr, cmd_fifo_empty;
  logic [6:0]  cmd_size, cmd_idx;
  logic [9:0]  cmd_fifo_wr_count;
  logic [31:0] cmd, weight_addr, data_addr, result_addr;
  logic        cmd_fifo_rd_en, dma_reads_en, padding, engine_reset, irq, err;
  logic [2:0]  eng_ready, eng_valid, op_type;
  logic [3:0]  stride;
  logic [19:0] op_num;
  logic [15:0] i_ch, o_ch, o_surf;
  logic [7:0]  i_side, o_side;

  int n_checks = 0;
  int n_errors = 0;
  int rd_empty_viol = 0;
  int stall_cnt = 0;
  int n_popped = 0;
  bit stall_mode = 1'b0;
  logic [31:0] fifo_q[$];
  cmd_t prog_q[$];

  always #5 clk = ~clk;

  csb_seq dut (
    .clk(clk), .rst_n(rst_n), .op_en(op_en), .abort(abort), .irq_clr(irq_clr),
    .cmd_size(cmd_size), .cmd_fifo_wr_count(cmd_fifo_wr_count),
    .cmd_fifo_empty(cmd_fifo_empty), .cmd(cmd), .cmd_fifo_rd_en(cmd_fifo_rd_en),
    .dma_reads_en(dma_reads_en), .eng_ready(eng_ready), .eng_valid(eng_valid),
    .op_type(op_type), .padding(padding), .stride(stride), .op_num(op_num),
    .i_ch(i_ch), .o_ch(o_ch), .i_side(i_side), .o_side(o_side), .o_surf(o_surf),
    .weight_addr(weight_addr), .data_addr(data_addr), .result_addr(result_addr),
    .engine_reset(engine_reset), .irq(irq), .err(err), .cmd_idx(cmd_idx)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t make_cmd(input logic [2:0] op, input int och, input int osurf);
    cmd_t c;
    c.op = op;          c.pad = 1'($urandom);     c.stride = 4'($urandom);
    c.num = 20'($urandom); c.ich = 16'($urandom); c.och = 16'(och);
    c.iside = 8'($urandom); c.oside = 8'($urandom); c.osurf = 16'(osurf);
    c.wa = $urandom;    c.da = $urandom;          c.ra = $urandom;
    return c;
  endfunction

  function automatic logic [31:0] word_of(input cmd_t c, input int k);
    case (k)
      0: return {4'd0, c.num, c.stride, c.pad, c.op};
      1: return {c.och, c.ich};
      2: return {c.osurf, c.oside, c.iside};
      3: return c.wa;
      4: return c.da;
      default: return c.ra;
    endcase
  endfunction

  function automatic logic [31:0] obs_word(input int k);
    case (k)
      0: return {4'd0, op_num, stride, padding, op_type};
      1: return {o_ch, i_ch};
      2: return {o_surf, o_side, i_side};
      3: return weight_addr;
      4: return data_addr;
      default: return result_addr;
    endcase
  endfunction

  function automatic int exp_engine(input logic [2:0] op);
    if (op >= 3'd1 && op <= 3'd3) return 0;
    else if (op == 3'd4) return 1;
    else if (op == 3'd5) return 2;
    else return -1;
  endfunction

  function automatic logic [2:0] noise(input int e);
    logic [2:0] n;
    n = 3'($urandom_range(0, 7));
    n[e] = 1'b0;
    return n;
  endfunction

  task automatic update_pins();
    cmd_fifo_empty    = (fifo_q.size() == 0) || (stall_cnt > 0);
    cmd               = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
    cmd_fifo_wr_count = 10'(fifo_q.size());
  endtask

  task automatic tick();
    logic pop_s, empty_s;
    @(negedge clk);
    pop_s   = cmd_fifo_rd_en;
    empty_s = cmd_fifo_empty;
    if (pop_s && empty_s) rd_empty_viol++;
    @(posedge clk);
    #1;
    if (pop_s && !empty_s && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      n_popped++;
      if (stall_mode && (n_popped % 6 == 3)) stall_cnt = 5;
    end else if (stall_cnt > 0) begin
      stall_cnt--;
    end
    update_pins();
    op_en = 1'b0; abort = 1'b0; irq_clr = 1'b0; eng_valid = 3'b000;
  endtask

  task automatic wait_ready(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (eng_ready != 3'b000 || err) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic start_program(input int size, input bit chk_dma);
    abort = 1'b1;
    tick();
    fifo_q.delete();
    stall_cnt = 0;
    n_popped = 0;
    foreach (prog_q[i]) for (int k = 0; k < 6; k++) fifo_q.push_back(word_of(prog_q[i], k));
    cmd_size = 7'(size);
    update_pins();
    op_en = 1'b1;
    tick();
    check_val("err_cleared", err, 1'b0);
    check_val("cmd_idx_start", cmd_idx, 7'd0);
    if (chk_dma) begin
      check_val("dma_set", dma_reads_en, 1'b1);
      tick();
      check_val("dma_full", dma_reads_en, 1'b0);
    end
  endtask

  task automatic run_op(input cmd_t c, input int idx, input bit last);
    bit to, early;
    int e, p;
    wait_ready(to);
    check_val("ready_timeout", to, 1'b0);
    e = exp_engine(c.op);
    check_val("eng_ready_sel", eng_ready, 3'b001 << e);
    check_val("eng_rst_low", engine_reset, 1'b0);
    for (int k = 0; k < 6; k++) check_val($sformatf("word%0d", k), obs_word(k), word_of(c, k));
    p = int'(c.osurf) * ((int'(c.och) + 15) / 16);
    early = 1'b0;
    for (int k = 1; k <= p; k++) begin
      repeat ($urandom_range(0, 2)) begin
        eng_valid = noise(e);
        tick();
      end
      eng_valid = (3'b001 << e) | noise(e);
      tick();
      if (k < p && eng_ready == 3'b000) begin
        early = 1'b1;
        break;
      end
    end
    check_val("op_not_early", early, 1'b0);
    check_val("ready_fall", eng_ready, 3'b000);
    check_val("eng_rst_high", engine_reset, 1'b1);
    check_val("cmd_idx", cmd_idx, 7'(idx + 1));
    if (last) begin
      check_val("irq_not_yet", irq, 1'b0);
      tick();
      check_val("irq_rise", irq, 1'b1);
    end
  endtask

  task automatic run_program(input int size, input bit chk_dma);
    start_program(size, chk_dma);
    for (int i = 0; i < size; i++) run_op(prog_q[i], i, i == size - 1);
    repeat (3) tick();
    check_val("irq_sticky", irq, 1'b1);
    irq_clr = 1'b1;
    tick();
    check_val("irq_cleared", irq, 1'b0);
  endtask

  task automatic run_illegal(input cmd_t c, input int size);
    bit to;
    prog_q.delete();
    prog_q.push_back(c);
    start_program(size, 1'b0);
    wait_ready(to);
    check_val("err_timeout", to, 1'b0);
    check_val("err_set", err, 1'b1);
    repeat (4) tick();
    check_val("err_no_ready", eng_ready, 3'b000);
    check_val("err_eng_rst", engine_reset, 1'b1);
    abort = 1'b1;
    tick();
    check_val("err_kept", err, 1'b1);
    check_val("abort_eng_rst", engine_reset, 1'b1);
  endtask

  initial begin
    bit to;
    cmd_t c;
    rst_n = 1'b0; op_en = 1'b0; abort = 1'b0; irq_clr = 1'b0; eng_valid = 3'b000;
    cmd_size = 7'd0;
    update_pins();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", eng_ready, 3'b000);
    check_val("rst_eng_rst", engine_reset, 1'b1);
    check_val("rst_flags", {irq, err, dma_reads_en, cmd_fifo_rd_en}, 4'b0000);
    check_val("rst_cmd_idx", cmd_idx, 7'd0);
    check_val("rst_op_type", op_type, 3'd0);
    rst_n = 1'b1;
    tick();

    // conv, 2 sweeps x 4 surfaces
    prog_q.delete(); prog_q.push_back(make_cmd(3'd2, 32, 4));
    run_program(1, 1'b1);
    // ragged tail: 40 channels need 3 sweeps
    prog_q.delete(); prog_q.push_back(make_cmd(3'd1, 40, 4));
    run_program(1, 1'b0);
    // FIFO empty for 5 cycles inside the command
    stall_mode = 1'b1;
    prog_q.delete(); prog_q.push_back(make_cmd(3'd3, 17, 2));
    run_program(1, 1'b0);
    stall_mode = 1'b0;
    // chain over all three engines
    prog_q.delete();
    prog_q.push_back(make_cmd(3'd2, 16, 2));
    prog_q.push_back(make_cmd(3'd4, 20, 1));
    prog_q.push_back(make_cmd(3'd5, 48, 3));
    run_program(3, 1'b0);
    check_val("chain_idx", cmd_idx, 7'd3);

    run_illegal(make_cmd(3'd7, 16, 4), 1);
    run_illegal(make_cmd(3'd0, 16, 4), 1);
    run_illegal(make_cmd(3'd4, 0, 4), 1);
    run_illegal(make_cmd(3'd4, 16, 0), 1);
    run_illegal(make_cmd(3'd2, 16, 4), 0);

    // abort while collecting blocks the pop
    prog_q.delete(); prog_q.push_back(make_cmd(3'd2, 32, 4));
    start_program(1, 1'b0);
    abort = 1'b1;
    #1;
    check_val("abort_no_pop", cmd_fifo_rd_en, 1'b0);
    tick();
    check_val("abort_dma", dma_reads_en, 1'b0);

    // abort after 2 pulses, then a clean restart of the same op
    start_program(1, 1'b0);
    wait_ready(to);
    check_val("abort_ready_to", to, 1'b0);
    repeat (2) begin
      eng_valid = 3'b001;
      tick();
    end
    abort = 1'b1;
    tick();
    check_val("abort_ready", eng_ready, 3'b000);
    check_val("abort_rst", engine_reset, 1'b1);
    check_val("abort_irq", irq, 1'b0);
    run_program(1, 1'b0);

    for (int p = 0; p < 4; p++) begin
      int sz;
      sz = $urandom_range(1, 4);
      stall_mode = 1'($urandom);
      prog_q.delete();
      for (int i = 0; i < sz; i++)
        prog_q.push_back(make_cmd(3'($urandom_range(1, 5)), $urandom_range(1, 70), $urandom_range(1, 4)));
      run_program(sz, 1'b0);
    end
    stall_mode = 1'b0;

    // async reset in the middle of an op
    prog_q.delete(); prog_q.push_back(make_cmd(3'd5, 32, 4));
    start_program(1, 1'b0);
    wait_ready(to);
    check_val("arst_ready_to", to, 1'b0);
    eng_valid = 3'b100;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_ready", eng_ready, 3'b000);
    check_val("arst_eng_rst", engine_reset, 1'b1);
    check_val("arst_idx", cmd_idx, 7'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fifo_q.delete();
    update_pins();
    tick();

    check_val("rd_when_empty", 32'(rd_empty_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
